uart_rx_oversampled: RTL and testbench
======================================

Name: uart_rx_oversampled

Overview:
UART receiver that turns the serial rx line into parallel bytes. A single-cycle baud_tick strobe at OVERSAMPLE × baud rate times all sampling; the strobe comes from the team's baud/clock generator, with edge-detection upstream if needed. The receiver finds the start bit, samples each bit at mid-bit, and checks parity and stop. Each received word goes into a one-entry output buffer with a valid/ready handshake to the consuming logic.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..9), sent LSB first
OVERSAMPLE, 16, baud_tick strobes per bit period (even, >= 4)
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only when PARITY_EN=1)

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
baud_tick  input  1  one-clk enable strobe at OVERSAMPLE × baud
rx  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received word; stable while rx_valid=1
rx_valid  output  1  rx_data, frame_err and parity_err are valid
rx_ready  input  1  consumer accepts the word when rx_valid & rx_ready
frame_err  output  1  stop bit sampled low for the buffered word
parity_err  output  1  parity mismatch for the buffered word
overrun  output  1  one-clk pulse: a completed frame was dropped because the buffer was full

Behaviour:
- Reset: state=IDLE; synchronizer flops=1; tick counter=0; bit counter=0; shift register=0; rx_data=0; rx_valid=0; frame_err=0; parity_err=0; overrun=0. Reset takes effect mid-frame at once and the partial frame is discarded.
- rx passes through a 2-flop synchronizer (rx_s) before any use.
- All state, counter and sample updates happen only on clk edges where baud_tick=1. The exceptions are the handshake and overrun logic, which evaluate every clk.
- Tick counter width is clog2(OVERSAMPLE). It clears on every state entry.
- IDLE: on a tick with rx_s=0, go to START.
- START: when the tick count reaches OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - If rx_s=1, the start was false (glitch): return to IDLE and deliver nothing.
  - If rx_s=0, go to DATA.
- DATA: sample rx_s each time the count reaches OVERSAMPLE-1. Shift the sample in at the MSB and shift right, so the first bit ends up as the LSB. After DATA_BITS samples, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: sample at OVERSAMPLE-1. The error condition is (XOR of data bits XOR sample XOR PARITY_ODD) != 0. Then go to STOP.
- STOP: sample at OVERSAMPLE-1, which is mid stop bit. This is the frame-complete event.
  - If rx_s=1: go to IDLE.
  - If rx_s=0: set frame_err for this word and go to BREAK.
- BREAK: wait for a tick with rx_s=1, then go to IDLE. While the line is held low, no new frames start.
- Frame complete with buffer empty (rx_valid=0): on the next clk, load rx_data and the error flags and set rx_valid=1. Latency is 1 clk after the completing tick edge.
- A word with frame_err or parity_err is still delivered; the flags qualify it.
- Handshake:
  - rx_valid stays high, and rx_data and the flags stay stable, until a clk with rx_valid & rx_ready. rx_valid then clears on that edge.
  - rx_ready=1 while rx_valid=0 has no effect.
- Frame complete while rx_valid=1 and rx_ready=0 on that same clk: the new word is dropped, the buffer keeps the old word, and overrun pulses high for exactly 1 clk.
- Frame complete on the same clk as an accept (rx_valid & rx_ready): no overrun. The new word loads and rx_valid stays 1.
- The next start bit can be detected on the first tick after returning to IDLE, i.e. from mid stop bit onward.
- baud_tick held at 0 freezes the FSM. Handshake outputs still respond to rx_ready.

Test Plan:
- Basic frame (OVERSAMPLE=16, baud_tick every 4 clk, rx_ready=1): send 0xA5 with stop=1 → rx_valid pulses 1 clk with rx_data=0xA5, frame_err=0, parity_err=0, overrun=0.
- Glitch: rx low for 5 ticks, then high → no rx_valid, FSM back in IDLE. A following 0x3C frame is received correctly.
- Framing / break: send 0x55 with stop bit=0, then hold rx low for 40 ticks → rx_data=0x55 with frame_err=1. No new frame starts until rx returns high; the next 0x81 frame is received with frame_err=0.
- Parity (PARITY_EN=1, PARITY_ODD=0): send 0x07 with parity bit 1 → parity_err=0. Send 0x07 with parity bit 0 → parity_err=1 and the data is still delivered.
- Overrun: with rx_ready=0, send 0x11 then 0x22 → rx_data stays 0x11 and overrun pulses 1 clk at the second frame's completion. Then raise rx_ready → 0x11 is accepted and rx_valid=0. Also place the second frame's completion on the same clk as the accept → no overrun and rx_data=0x22.
- Reset mid-frame: assert reset_n=0 during data bit 4, release, send 0xF0 → all outputs 0 during reset, then 0xF0 received cleanly with no errors.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: start/data/parity/stop sampling on baud_tick,
// delivering each word through a one-entry valid/ready buffer.
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic ODD     = (PARITY_ODD != 0);
    localparam logic HAS_PAR = (PARITY_EN != 0);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 fe_q;
    logic                 pe_q;
    logic                 done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // done marks the tick that sampled the stop bit; the buffer acts on it next clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (baud_tick) begin
                cnt <= cnt + CW'(1);
                unique case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= START;
                        end
                    end
                    START: begin
                        if (cnt == MID) begin
                            cnt <= '0;
                            if (rx_s) begin
                                state <= IDLE;
                            end else begin
                                state   <= DATA;
                                bit_cnt <= '0;
                                fe_q    <= 1'b0;
                                pe_q    <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        if (cnt == LAST) begin
                            cnt     <= '0;
                            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + BW'(1);
                            if (bit_cnt == LAST_BIT) begin
                                state <= HAS_PAR ? PARITY : STOP;
                            end
                        end
                    end
                    PARITY: begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            pe_q  <= (^shreg) ^ rx_s ^ ODD;
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            done  <= 1'b1;
                            fe_q  <= ~rx_s;
                            state <= rx_s ? IDLE : BREAK;
                        end
                    end
                    BREAK: begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // An accept on the completing clk frees the buffer, so no overrun then
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (rx_valid && !rx_ready) begin
                    overrun <= 1'b1;
                end else begin
                    rx_data    <= shreg;
                    frame_err  <= fe_q;
                    parity_err <= pe_q;
                    rx_valid   <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed and randomized frames for uart_rx_oversampled, checked against
// a frame-level model of delivered words (plain and even-parity instances).
module tb_uart_rx_oversampled;

    localparam int OS  = 16;
    localparam int DIV = 4;
    localparam int BP  = OS * DIV;
    localparam logic P_ODD = 1'b0;
    // clk edges from the aligned tick to the stop-bit sample (no parity)
    localparam int STOP_EDGE = DIV + DIV * (OS / 2) + 9 * BP;

    logic       clk;
    logic       reset_n;
    logic       baud_tick;
    logic       rx0, rx1;
    logic       rdy0, rdy1;
    logic [7:0] d0, d1;
    logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    int vcyc0   = 0;
    int ov_cnt0 = 0;
    int ov_run0 = 0;
    int ov_max0 = 0;
    int ov_cnt1 = 0;

    uart_rx_oversampled #(
        .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx(rx0),
        .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
        .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
    );

    uart_rx_oversampled #(
        .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)
    ) dut_p (
        .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx(rx1),
        .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
        .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (v0 && rdy0) q0.push_back({fe0, pe0, d0});
            if (v1 && rdy1) q1.push_back({fe1, pe1, d1});
            if (v0) vcyc0 <= vcyc0 + 1;
            if (ov0) begin
                ov_cnt0 <= ov_cnt0 + 1;
                ov_run0 <= ov_run0 + 1;
                if (ov_run0 + 1 > ov_max0) ov_max0 <= ov_run0 + 1;
            end else begin
                ov_run0 <= 0;
            end
            if (ov1) ov_cnt1 <= ov_cnt1 + 1;
        end
    end

    function automatic logic [9:0] model(input logic [7:0] d, input logic parbit,
                                         input logic stopb, input bit par_en);
        logic pe;
        pe = par_en ? (((^d) ^ parbit ^ P_ODD) != 1'b0) : 1'b0;
        return {~stopb, pe, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input int sel, input logic [9:0] exp, input string tag);
        logic [9:0] got;
        got = 'x;
        if (sel == 0) begin
            check({tag, "_n"}, q0.size(), 1);
            if (q0.size() > 0) got = q0.pop_front();
            q0.delete();
        end else begin
            check({tag, "_n"}, q1.size(), 1);
            if (q1.size() > 0) got = q1.pop_front();
            q1.delete();
        end
        check(tag, got, exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_v0"}, v0, 0);
        check({tag, "_d0"}, d0, 0);
        check({tag, "_fe0"}, fe0, 0);
        check({tag, "_pe0"}, pe0, 0);
        check({tag, "_ov0"}, ov0, 0);
        check({tag, "_v1"}, v1, 0);
        check({tag, "_d1"}, d1, 0);
        check({tag, "_fe1"}, fe1, 0);
        check({tag, "_pe1"}, pe1, 0);
        check({tag, "_ov1"}, ov1, 0);
    endtask

    task automatic drive(input int sel, input logic val, input int n);
        if (sel == 0) rx0 = val;
        else rx1 = val;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align_tick();
        do @(posedge clk); while (!baud_tick);
        #1;
    endtask

    task automatic send(input int sel, input logic [7:0] d, input logic parbit,
                        input logic stopb, input int extra_low, input bit align);
        if (align) align_tick();
        drive(sel, 1'b0, BP);
        for (int i = 0; i < 8; i++) drive(sel, d[i], BP);
        if (sel == 1) drive(sel, parbit, BP);
        drive(sel, stopb, BP + (stopb ? 0 : extra_low));
        drive(sel, 1'b1, BP);
    endtask

    initial begin
        int vb;
        int ovb;
        int sel;
        logic [7:0] d;
        logic pb, sb;

        reset_n = 1'b0;
        rx0 = 1'b1;
        rx1 = 1'b1;
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rdy0 = 1'b1;
        rdy1 = 1'b1;

        vb = vcyc0;
        ovb = ov_cnt0;
        send(0, 8'hA5, 1'b0, 1'b1, 0, 1);
        check_word(0, model(8'hA5, 1'b0, 1'b1, 0), "basic");
        check("basic_vlen", vcyc0 - vb, 1);
        check("basic_ov", ov_cnt0 - ovb, 0);

        align_tick();
        drive(0, 1'b0, 5 * DIV);
        drive(0, 1'b1, 3 * BP);
        check("glitch_n", q0.size(), 0);
        check("glitch_v", v0, 0);
        send(0, 8'h3C, 1'b0, 1'b1, 0, 1);
        check_word(0, model(8'h3C, 1'b0, 1'b1, 0), "after_glitch");

        send(0, 8'h55, 1'b0, 1'b0, 40 * DIV, 1);
        check_word(0, model(8'h55, 1'b0, 1'b0, 0), "break");
        send(0, 8'h81, 1'b0, 1'b1, 0, 1);
        check_word(0, model(8'h81, 1'b0, 1'b1, 0), "after_break");

        send(1, 8'h07, 1'b1, 1'b1, 0, 1);
        check_word(1, model(8'h07, 1'b1, 1'b1, 1), "par_ok");
        send(1, 8'h07, 1'b0, 1'b1, 0, 1);
        check_word(1, model(8'h07, 1'b0, 1'b1, 1), "par_bad");
        check("par_ov", ov_cnt1, 0);

        for (int i = 0; i < 8; i++) begin
            sel = int'($urandom_range(0, 1));
            d = 8'($urandom);
            pb = 1'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            send(sel, d, pb, sb, 0, 1);
            check_word(sel, model(d, pb, sb, sel == 1), $sformatf("rand%0d", i));
        end

        rdy0 = 1'b0;
        send(0, 8'h11, 1'b0, 1'b1, 0, 1);
        check("ovr_v1", v0, 1);
        check("ovr_d1", d0, 8'h11);
        ovb = ov_cnt0;
        send(0, 8'h22, 1'b0, 1'b1, 0, 1);
        check("ovr_v2", v0, 1);
        check("ovr_d2", d0, 8'h11);
        check("ovr_pulses", ov_cnt0 - ovb, 1);
        check("ovr_width", ov_max0, 1);
        rdy0 = 1'b1;
        @(posedge clk);
        #1;
        rdy0 = 1'b0;
        check("ovr_acc_v", v0, 0);
        check_word(0, model(8'h11, 1'b0, 1'b1, 0), "ovr_acc");

        send(0, 8'h11, 1'b0, 1'b1, 0, 1);
        check("same_v1", v0, 1);
        ovb = ov_cnt0;
        align_tick();
        fork
            send(0, 8'h22, 1'b0, 1'b1, 0, 0);
            begin
                repeat (STOP_EDGE) @(posedge clk);
                #1 rdy0 = 1'b1;
                @(posedge clk);
                #1 rdy0 = 1'b0;
            end
        join
        check("same_v", v0, 1);
        check("same_d", d0, 8'h22);
        check("same_ov", ov_cnt0 - ovb, 0);
        check_word(0, model(8'h11, 1'b0, 1'b1, 0), "same_acc");
        rdy0 = 1'b1;
        @(posedge clk);
        #1;
        check_word(0, model(8'h22, 1'b0, 1'b1, 0), "same_next");
        check("same_v0", v0, 0);

        rdy0 = 1'b0;
        send(0, 8'h99, 1'b0, 1'b1, 0, 1);
        check("mid_pre_v", v0, 1);
        align_tick();
        fork
            send(0, 8'hC3, 1'b0, 1'b1, 0, 0);
            begin
                repeat (5 * BP + BP / 2) @(posedge clk);
                #1 reset_n = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check_zero("midrst");
            end
        join
        reset_n = 1'b1;
        rdy0 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_n", q0.size(), 0);
        send(0, 8'hF0, 1'b0, 1'b1, 0, 1);
        check_word(0, model(8'hF0, 1'b0, 1'b1, 0), "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
